// File: rtl/write_sequencer.sv
// Stack/store write sequencer: issues one to three single-cycle bus writes per request.
// Optional macro WRITE_SEQ_BFLAG_EN forces the B/unused status bits on the PC+P push.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module write_sequencer #(
  parameter int REG_WIDTH  = `REG_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [1:0]            wr_kind,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [REG_WIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [REG_WIDTH-1:0]  p_in,
  input  logic                  brk,
  input  logic [REG_WIDTH-1:0]  sp,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [REG_WIDTH-1:0]  data_out,
  output logic                  we,
  output logic                  busy,
  output logic                  write_done,
  output logic [REG_WIDTH-1:0]  sp_next,
  output logic                  sp_update
);

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, BYTE2} state_t;

  state_t                  state_r;
  logic [1:0]              kind_r;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic [REG_WIDTH-1:0]    pstat_r;
  logic [REG_WIDTH-1:0]    sp_r;
  logic                    last_s;

  // Pushes stay inside the stack page: only the low byte of the address moves.
  function automatic logic [ADDR_WIDTH-1:0] stack_addr(input logic [REG_WIDTH-1:0] s);
    return STACK_BASE + {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, s};
  endfunction

  function automatic logic [1:0] byte_count(input logic [1:0] kind);
    case (kind)
      2'b10:   return 2'd2;
      2'b11:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

`ifdef WRITE_SEQ_BFLAG_EN
  function automatic logic [REG_WIDTH-1:0] status_byte(input logic [REG_WIDTH-1:0] p, input logic b);
    return {p[7:6], 1'b1, b, p[3:0]};
  endfunction
`else
  logic unused_brk_s;
  assign unused_brk_s = brk;

  function automatic logic [REG_WIDTH-1:0] status_byte(input logic [REG_WIDTH-1:0] p, input logic b);
    logic unused_b;
    unused_b = b;
    return p;
  endfunction
`endif

  // Flags the cycle whose byte is the final one of the current sequence.
  always_comb begin
    last_s = 1'b0;
    case (state_r)
      BYTE0:   last_s = ~kind_r[1];
      BYTE1:   last_s = (kind_r != 2'b11);
      BYTE2:   last_s = 1'b1;
      default: last_s = 1'b0;
    endcase
  end

  // Sequencer state, operand latches and all registered bus/handshake outputs.
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      kind_r     <= 2'b00;
      pc_r       <= {ADDR_WIDTH{1'b0}};
      pstat_r    <= {REG_WIDTH{1'b0}};
      sp_r       <= {REG_WIDTH{1'b0}};
      addr       <= {ADDR_WIDTH{1'b0}};
      data_out   <= {REG_WIDTH{1'b0}};
      we         <= 1'b0;
      busy       <= 1'b0;
      write_done <= 1'b0;
      sp_update  <= 1'b0;
      sp_next    <= {REG_WIDTH{1'b0}};
    end else begin
      write_done <= 1'b0;
      sp_update  <= 1'b0;
      if (state_r == IDLE) begin
        if (wr_req) begin
          kind_r   <= wr_kind;
          pc_r     <= pc_in;
          pstat_r  <= status_byte(p_in, brk);
          sp_r     <= sp;
          we       <= 1'b1;
          busy     <= 1'b1;
          state_r  <= BYTE0;
          addr     <= (wr_kind == 2'b00) ? wr_addr : stack_addr(sp);
          data_out <= wr_kind[1] ? pc_in[ADDR_WIDTH-1 -: REG_WIDTH] : wr_data;
        end else begin
          we   <= 1'b0;
          busy <= 1'b0;
        end
      end else if (last_s) begin
        we         <= 1'b0;
        busy       <= 1'b0;
        write_done <= 1'b1;
        state_r    <= IDLE;
        if (kind_r != 2'b00) begin
          sp_update <= 1'b1;
          sp_next   <= sp_r - REG_WIDTH'(byte_count(kind_r));
        end else begin
          sp_update <= 1'b0;
        end
      end else begin
        case (state_r)
          BYTE0: begin
            addr     <= stack_addr(sp_r - REG_WIDTH'(2'd1));
            data_out <= pc_r[REG_WIDTH-1:0];
            state_r  <= BYTE1;
          end
          BYTE1: begin
            addr     <= stack_addr(sp_r - REG_WIDTH'(2'd2));
            data_out <= pstat_r;
            state_r  <= BYTE2;
          end
          default: begin
            we      <= 1'b0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/write_sequencer.md
WRITE_SEQUENCER -- requirements
Module: write_sequencer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default `REG_WIDTH (8), data and stack-pointer width.
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (16), bus address width.
REQ-003 SHALL have parameter STACK_BASE, default 16'h0100, stack page base address.
REQ-004 SHALL have one clock and asynchronous, active-high reset; ports listed below.
REQ-005 phi1  input  1  clock; all state changes on posedge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 wr_req  input  1  write request, sampled only in IDLE.
REQ-008 wr_kind  input  2  00 store byte, 01 push byte, 10 push PC, 11 push PC+P.
REQ-009 wr_addr  input  ADDR_WIDTH  store target, used for kind 00 only.
REQ-010 wr_data  input  REG_WIDTH  byte for kinds 00/01.
REQ-011 pc_in  input  ADDR_WIDTH  PC for kinds 10/11.
REQ-012 p_in  input  REG_WIDTH  status for kind 11.
REQ-013 brk  input  1  break source flag for kind 11.
REQ-014 sp  input  REG_WIDTH  current stack pointer.
REQ-015 addr  output  ADDR_WIDTH  bus write address.
REQ-016 data_out  output  REG_WIDTH  bus write data.
REQ-017 we  output  1  bus write strobe.
REQ-018 busy  output  1  sequence in progress.
REQ-019 write_done  output  1  one-cycle completion pulse.
REQ-020 sp_next  output  REG_WIDTH  updated stack pointer.
REQ-021 sp_update  output  1  one-cycle pulse; sp_next valid.

Function
REQ-022 SHALL implement states IDLE, BYTE0, BYTE1, BYTE2; all outputs registered.
REQ-023 On a posedge in IDLE with wr_req=1: SHALL latch all inputs, drive the first byte (we=1, busy=1) and enter BYTE0.
REQ-024 Byte count: kinds 00/01 one, kind 10 two, kind 11 three; each byte SHALL hold we=1 for exactly one cycle, with consecutive bytes on consecutive cycles.
REQ-025 On the edge ending the last byte: SHALL drive we=0, busy=0, write_done=1 and return to IDLE.
REQ-026 Kind 00: addr=wr_addr, data_out=wr_data, sp_update=0.
REQ-027 Pushes: byte i addr = STACK_BASE + ((sp - i) mod 2^REG_WIDTH), so the address stays within the stack page (0x00 wraps to 0xFF).
REQ-028 Push order: PC[15:8], PC[7:0], then P.
REQ-029 For push kinds, sp_update SHALL pulse with write_done, with sp_next = (sp - count) mod 256.
REQ-030 wr_req while busy=1 SHALL be ignored, not queued; a request is accepted no earlier than the edge after write_done.
REQ-031 Latched operands SHALL be immune to input changes during a sequence.
REQ-032 write_done and sp_update SHALL be low in all other cycles; sp_next SHALL hold its last value.

Reset
REQ-033 reset=1 SHALL asynchronously force IDLE, addr=0, data_out=0, we=0, busy=0, write_done=0, sp_update=0, sp_next=0.
REQ-034 Reset mid-sequence SHALL abort without completing remaining bytes and without pulsing write_done or sp_update.

Configuration
REQ-035 Macro WRITE_SEQ_BFLAG_EN: when defined, the kind-11 status byte SHALL be {p_in[7:6], 1'b1, brk, p_in[3:0]}; when undefined, p_in SHALL be pushed unmodified and brk ignored.

Verification
REQ-036 Kind 10, pc_in=16'h1234, sp=8'hFD -> we cycles (01FD,12),(01FC,34); then write_done=1, sp_update=1, sp_next=8'hFB.
REQ-037 Kind 11, pc_in=16'hABCD, p_in=8'h00, brk=1, sp=8'h01, macro defined -> (0101,AB),(0100,CD),(01FF,30); sp_next=8'hFE.
REQ-038 Kind 00, wr_addr=16'h0200, wr_data=8'h5A -> single we cycle (0200,5A), write_done=1, sp_update=0.
REQ-039 wr_req pulsed during BYTE1 of a kind-11 push -> ignored; exactly 3 writes occur.
REQ-040 reset asserted during BYTE1 of kind 10 -> we=0 immediately; no write_done or sp_update; next request after release executes normally.
REQ-041 Kind 11 with macro undefined, p_in=8'h81, brk=1 -> third byte 81.
